// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DIVISOR  = 2'd2;
    localparam logic [1:0] REG_RESERVED = 2'd3;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_W   = 4;

    function automatic logic [31:0] pack_status(
        input logic                      busy,
        input logic                      full,
        input logic                      empty,
        input logic                      overflow,
        input logic [STATUS_COUNT_W-1:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_BUSY_BIT]  = busy;
        s[STATUS_FULL_BIT]  = full;
        s[STATUS_EMPTY_BIT] = empty;
        s[STATUS_OVF_BIT]   = overflow;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read; a push into a full FIFO is only
// accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    push_dropped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pop_data_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full         = (count_reg == FULL_COUNT);
    assign empty        = (count_reg == '0);
    assign pop_ok       = pop && !empty;
    assign push_ok      = push && (!full || pop_ok);
    assign push_dropped = push && !push_ok;
    assign count        = count_reg;
    assign pop_data     = pop_data_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (PTR_W+1)'(1);
            2'b01:   count_next = count_reg - (PTR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset so it maps onto RAM; read-first ordering hands the
    // popped word out even when a full-with-pop push overwrites that slot.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (pop_ok) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file, read mux,
// TX FIFO and the serialiser state machine.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o,
    output logic        hit_o,
    output logic        tx_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]  reg_idx;
    logic        bus_wr;
    logic        bus_rd;
    logic        txdata_push;
    logic        ovf_clear;
    logic        div_write;
    logic [15:0] div_wdata;

    logic [31:0] rvalue_reg;
    logic [31:0] rvalue_next;
    logic [15:0] divisor_reg;
    logic        overflow_reg;

    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_dropped;

    uart_tx_state_t state_reg;
    uart_tx_state_t state_next;
    logic [15:0]    bit_cnt_reg;
    logic [15:0]    bit_cnt_next;
    logic [2:0]     bit_idx_reg;
    logic [2:0]     bit_idx_next;
    logic [7:0]     shift_reg;
    logic [7:0]     shift_next;
    logic           tx_reg;
    logic           tx_next;
    logic           busy;
    logic [31:0]    status_word;

    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wvalue_i[31:16]};

    assign hit_o       = enable_i && (addr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx     = addr_i[3:2];
    assign bus_wr      = hit_o && (wstrb_i != 4'b0000);
    assign bus_rd      = hit_o && (wstrb_i == 4'b0000);
    assign txdata_push = bus_wr && (reg_idx == REG_TXDATA) && wstrb_i[0];
    assign ovf_clear   = bus_wr && (reg_idx == REG_STATUS) && wstrb_i[0] && wvalue_i[STATUS_OVF_BIT];
    assign div_write   = bus_wr && (reg_idx == REG_DIVISOR) && (wstrb_i[1:0] == 2'b11);
    // A zero divisor would stall the bit counter, so it is clamped to one.
    assign div_wdata   = (wvalue_i[15:0] == 16'd0) ? 16'd1 : wvalue_i[15:0];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push         (txdata_push),
        .push_data    (wvalue_i[7:0]),
        .pop          (fifo_pop),
        .pop_data     (fifo_rdata),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .push_dropped (fifo_dropped)
    );

    assign busy        = (state_reg != IDLE) || !fifo_empty;
    assign status_word = pack_status(busy, fifo_full, fifo_empty, overflow_reg,
                                     STATUS_COUNT_W'(fifo_count));

    always_comb begin
        rvalue_next = 32'd0;
        if (bus_rd) begin
            case (reg_idx)
                REG_STATUS:  rvalue_next = status_word;
                REG_DIVISOR: rvalue_next = {16'd0, divisor_reg};
                default:     rvalue_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalue_reg   <= 32'd0;
            divisor_reg  <= CLK_DIV;
            overflow_reg <= 1'b0;
        end else begin
            rvalue_reg <= rvalue_next;
            if (div_write) begin
                divisor_reg <= div_wdata;
            end
            if (fifo_dropped) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clear) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // The popped byte arrives from the FIFO's read register during START, so
    // the shifter is loaded from it when the first data bit goes out.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    bit_cnt_next = divisor_reg - 16'd1;
                    tx_next      = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_cnt_reg == 16'd0) begin
                    bit_cnt_next = divisor_reg - 16'd1;
                    tx_next      = fifo_rdata[0];
                    shift_next   = {1'b0, fifo_rdata[7:1]};
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt_reg == 16'd0) begin
                    bit_cnt_next = divisor_reg - 16'd1;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt_reg == 16'd0) begin
                    state_next = IDLE;
                end else begin
                    bit_cnt_next = bit_cnt_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    assign rvalue_o = rvalue_reg;
    assign tx_o     = tx_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus tasks drive the register window, a line receiver
// decodes frames and compares them against bytes queued at write time.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  wstrb_i = 4'b0000;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wvalue_i = 32'd0;
    logic [31:0] rvalue_o;
    logic        hit_o;
    logic        tx_o;

    always #5 clk_i = ~clk_i;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (16'd868),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .wstrb_i  (wstrb_i),
        .addr_i   (addr_i),
        .wvalue_i (wvalue_i),
        .rvalue_o (rvalue_o),
        .hit_o    (hit_o),
        .tx_o     (tx_o)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cur_div = 868;
    int         last_edge = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk_i);
        enable_i = 1'b1; addr_i = addr; wvalue_i = data; wstrb_i = strb;
        @(posedge clk_i); #1;
        last_edge = cyc;
        enable_i = 1'b0; wstrb_i = 4'b0000;
        $display("[edge %0d] write addr=%08h data=%08h strb=%b", last_edge, addr, data, strb);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        @(negedge clk_i);
        enable_i = 1'b1; addr_i = addr; wstrb_i = 4'b0000;
        #1 hit = hit_o;
        @(posedge clk_i); #1;
        last_edge = cyc;
        data = rvalue_o;
        enable_i = 1'b0;
        $display("[edge %0d] read  addr=%08h data=%08h hit=%b", last_edge, addr, data, hit);
    endtask

    // Returns just after edge e-1 so that the next bus access commits at edge e.
    task automatic wait_edge(input int e);
        while (cyc < e - 1) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        logic        h;
        int          n;
        s = 32'h1;
        n = 0;
        while (s[0] && n < budget) begin
            repeat (7) @(posedge clk_i);
            bus_read(BASE + 32'd4, s, h);
            n += 8;
        end
        check_eq("drain_busy", s & 32'h1, 32'h0);
    endtask

    // Line receiver: every cycle of every bit must hold the same level.
    int         m_state = 0;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ok = 1'b1;
    logic [7:0] m_exp;

    initial begin : rx_monitor
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: if (tx_o === 1'b0) begin
                        m_state = 1; m_cnt = 1; m_ok = 1'b1; m_byte = 8'h00;
                    end
                    1: if (m_cnt == cur_div) begin
                        m_byte[0] = tx_o; m_bit = 0; m_cnt = 1; m_state = 2;
                    end else begin
                        if (tx_o !== 1'b0) m_ok = 1'b0;
                        m_cnt++;
                    end
                    2: if (m_cnt == cur_div) begin
                        if (m_bit == 7) begin
                            if (tx_o !== 1'b1) m_ok = 1'b0;
                            m_cnt = 1; m_state = 3;
                        end else begin
                            m_bit++;
                            m_byte[m_bit] = tx_o;
                            m_cnt = 1;
                        end
                    end else begin
                        if (tx_o !== m_byte[m_bit]) m_ok = 1'b0;
                        m_cnt++;
                    end
                    default: if (m_cnt == cur_div) begin
                        if (tx_o !== 1'b1) m_ok = 1'b0;
                        $display("[edge %0d] rx byte=%02h framing_ok=%b", cyc, m_byte, m_ok);
                        if (exp_q.size() == 0) begin
                            check_eq("rx_queue_level", exp_q.size(), 1);
                        end else begin
                            m_exp = exp_q.pop_front();
                            check_eq("rx_byte", {24'd0, m_byte}, {24'd0, m_exp});
                        end
                        check_eq("rx_framing", {31'd0, m_ok}, 32'd1);
                        m_state = 0;
                    end else begin
                        if (tx_o !== 1'b1) m_ok = 1'b0;
                        m_cnt++;
                    end
                endcase
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic        hit;
        int          w;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b0;

        // Reset state
        check_eq("reset_tx", {31'd0, tx_o}, 32'd1);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("reset_status", rd, 32'h0000_0004);
        check_eq("status_hit", {31'd0, hit}, 32'd1);
        @(posedge clk_i); #1;
        check_eq("rvalue_after_idle", rvalue_o, 32'd0);
        bus_read(BASE + 32'd8, rd, hit);
        check_eq("reset_divisor", rd, 32'd868);
        bus_read(BASE, rd, hit);
        check_eq("txdata_read_zero", rd, 32'd0);

        // Single frame at DIVISOR=4
        bus_write(BASE + 32'd8, 32'd4, 4'b0011);
        cur_div = 4;
        bus_read(BASE + 32'd8, rd, hit);
        check_eq("divisor_4", rd, 32'd4);
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        w = last_edge;
        exp_q.push_back(8'hA5);
        wait_edge(w + 41);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("busy_last_stop_cycle", rd & 32'h1, 32'h1);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("busy_cleared", rd, 32'h0000_0004);
        check_eq("a5_drained", exp_q.size(), 0);

        // Overflow at DIVISOR=2
        bus_write(BASE + 32'd8, 32'd2, 4'b0011);
        cur_div = 2;
        bus_write(BASE, 32'h0000_0011, 4'b0001);
        w = last_edge;
        exp_q.push_back(8'h11);
        for (int i = 1; i <= 9; i++) begin
            bus_write(BASE, 32'h20 + 32'(i), 4'b0001);
            if (i <= 8) exp_q.push_back(8'(8'h20 + i));
        end
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("status_overflow", rd, 32'h0000_080B);
        bus_write(BASE + 32'd4, 32'h0000_0008, 4'b0001);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("status_ovf_cleared", rd, 32'h0000_0803);

        // Push into the full FIFO in the cycle the FSM pops
        wait_edge(w + 22);
        bus_write(BASE, 32'h0000_005A, 4'b0001);
        exp_q.push_back(8'h5A);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("full_push_with_pop", rd, 32'h0000_0803);
        wait_idle(3000);
        check_eq("burst_drained", exp_q.size(), 0);

        // Reset during data bit 3
        bus_write(BASE + 32'd8, 32'd4, 4'b0011);
        cur_div = 4;
        bus_write(BASE, 32'h0000_00C5, 4'b0001);
        w = last_edge;
        exp_q.push_back(8'hC5);
        while (cyc < w + 18) begin
            @(posedge clk_i); #1;
        end
        #2;
        check_eq("tx_bit3_low", {31'd0, tx_o}, 32'd0);
        rst_i = 1'b1;
        exp_q.delete();
        cur_div = 868;
        #1;
        check_eq("async_reset_tx", {31'd0, tx_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_i = 1'b0;
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("status_after_reset", rd, 32'h0000_0004);
        bus_read(BASE + 32'd8, rd, hit);
        check_eq("divisor_after_reset", rd, 32'd868);
        bus_write(BASE + 32'd8, 32'd4, 4'b0011);
        cur_div = 4;
        bus_write(BASE, 32'h0000_0096, 4'b0001);
        exp_q.push_back(8'h96);
        wait_idle(2000);
        check_eq("post_reset_drained", exp_q.size(), 0);

        // Decode boundaries and divisor corner cases
        bus_read(BASE + 32'd16, rd, hit);
        check_eq("outside_hit", {31'd0, hit}, 32'd0);
        check_eq("outside_rvalue", rd, 32'd0);
        bus_write(BASE + 32'd16, 32'h0000_0077, 4'b0001);
        bus_read(BASE + 32'd4, rd, hit);
        check_eq("outside_write_no_push", rd, 32'h0000_0004);
        bus_write(BASE + 32'd12, 32'hFFFF_FFFF, 4'b1111);
        bus_read(BASE + 32'd12, rd, hit);
        check_eq("reserved_hit", {31'd0, hit}, 32'd1);
        check_eq("reserved_reads_zero", rd, 32'd0);
        bus_write(BASE + 32'd8, 32'd0, 4'b0011);
        bus_read(BASE + 32'd8, rd, hit);
        check_eq("divisor_zero_clamped", rd, 32'd1);
        bus_write(BASE + 32'd8, 32'h0000_0055, 4'b0001);
        bus_read(BASE + 32'd8, rd, hit);
        check_eq("divisor_partial_strobe", rd, 32'd1);

        repeat (4) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
